// File: rtl/mmio_port_pkg.sv
// Shared constants for mmio_port_responder: register offsets, STATUS/CTRL bit positions, entry width.
// Build option MMIO_PORT_TIMESTAMP_EN selects 32-bit {timestamp, PortIn} FIFO entries.
package mmio_port_pkg;

  localparam logic [4:0] OFF_PORT_OUT = 5'h00;
  localparam logic [4:0] OFF_PORT_IN  = 5'h04;
  localparam logic [4:0] OFF_STATUS   = 5'h08;
  localparam logic [4:0] OFF_FIFO     = 5'h0C;
  localparam logic [4:0] OFF_CTRL     = 5'h10;

  localparam int ST_EMPTY_BIT   = 0;
  localparam int ST_FULL_BIT    = 1;
  localparam int ST_OVF_BIT     = 2;
  localparam int ST_COUNT_LSB   = 3;

  localparam int CTRL_CAPEN_BIT = 0;
  localparam int CTRL_IRQEN_BIT = 1;
  localparam int CTRL_CLEAR_BIT = 2;

`ifdef MMIO_PORT_TIMESTAMP_EN
  localparam int ENTRY_W = 32;
`else
  localparam int ENTRY_W = 8;
`endif

  // Field order matches the ST_* bit positions above
  function automatic logic [31:0] status_word(input logic empty, input logic full,
                                              input logic ovf, input logic [4:0] count);
    status_word = {24'd0, count, ovf, full, empty};
  endfunction

endpackage

// File: rtl/mmio_port_responder_if.sv
// Data-memory side bus between the core's load/store path and mmio_port_responder.
interface mmio_port_responder_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (output MemWrite, MemRead, Address, WriteData, input ReadData, Hit);
  modport slave  (input MemWrite, MemRead, Address, WriteData, output ReadData, Hit);
endinterface

// File: rtl/port_capture_fifo.sv
// Small circular FIFO: synchronous push, combinational head, clear has priority over push/pop.
module port_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign empty_o = (count_q == CW'(0));
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees a slot the same cycle
  always_comb begin
    do_pop_s  = pop_i && !empty_o;
    do_push_s = push_i && (!full_o || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO window beside DataMemory: PortOut register, synchronized PortIn, change-capture FIFO.
// Build option MMIO_PORT_TIMESTAMP_EN tags each captured entry with a 24-bit cycle count.
module mmio_port_responder
  import mmio_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_port_responder_if.slave bus,
  input  logic [7:0]           PortIn,
  output logic [31:0]          PortOut,
  output logic                 IrqPending
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]        off_s;
  logic               hit_s;
  logic [2:0]         word_s;
  logic               unused_addr_s;
  logic               wr_en_s, rd_en_s, ctrl_wr_s, clear_s, push_s, pop_s;
  logic [7:0]         sync_q [SYNC_STAGES];
  logic [7:0]         sync_out_s, prev_q;
  logic [31:0]        port_out_q, port_out_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               ovf_q, ovf_d;
  logic               empty_s, full_s;
  logic [CW-1:0]      count_s;
  logic [ENTRY_W-1:0] push_data_s, head_s;
  logic [31:0]        rdata_s;

  // Unsigned offset covers both window bounds; byte-lane bits are ignored
  assign off_s         = bus.Address - BASE_ADDR;
  assign hit_s         = (off_s[31:5] == 27'd0);
  assign word_s        = off_s[4:2];
  assign unused_addr_s = ^off_s[1:0];
  assign sync_out_s    = sync_q[SYNC_STAGES-1];

  assign bus.Hit      = hit_s;
  assign bus.ReadData = rdata_s;
  assign PortOut      = port_out_q;
  assign IrqPending   = !empty_s && ctrl_q[CTRL_IRQEN_BIT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'd0;
      prev_q <= 8'd0;
    end else begin
      sync_q[0] <= PortIn;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_out_s;
    end
  end

`ifdef MMIO_PORT_TIMESTAMP_EN
  logic [23:0] ts_q;

  // Free-running cycle counter; its pre-edge value tags the entry pushed on that edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_q <= 24'd0;
    else        ts_q <= ts_q + 24'd1;
  end

  assign push_data_s = {ts_q, sync_out_s};
`else
  assign push_data_s = sync_out_s;
`endif

  always_comb begin
    wr_en_s    = bus.MemWrite && hit_s;
    rd_en_s    = bus.MemRead && hit_s;
    ctrl_wr_s  = wr_en_s && (word_s == OFF_CTRL[4:2]);
    clear_s    = ctrl_wr_s && bus.WriteData[CTRL_CLEAR_BIT];
    pop_s      = rd_en_s && (word_s == OFF_FIFO[4:2]) && !empty_s;
    push_s     = (sync_out_s != prev_q) && ctrl_q[CTRL_CAPEN_BIT];
    port_out_d = port_out_q;
    ctrl_d     = ctrl_q;
    ovf_d      = ovf_q;
    if (wr_en_s && (word_s == OFF_PORT_OUT[4:2])) port_out_d = bus.WriteData;
    else                                          port_out_d = port_out_q;
    if (ctrl_wr_s) ctrl_d = bus.WriteData[1:0];
    else           ctrl_d = ctrl_q;
    // A pop in the same cycle makes room, so only an unrelieved full push overflows
    if (clear_s)                            ovf_d = 1'b0;
    else if (push_s && full_s && !pop_s)    ovf_d = 1'b1;
    else                                    ovf_d = ovf_q;
  end

  always_comb begin
    rdata_s = 32'd0;
    if (hit_s) begin
      case (word_s)
        OFF_PORT_OUT[4:2]: rdata_s = port_out_q;
        OFF_PORT_IN[4:2]:  rdata_s = {24'd0, sync_out_s};
        OFF_STATUS[4:2]:   rdata_s = status_word(empty_s, full_s, ovf_q, 5'(count_s));
        OFF_FIFO[4:2]:     rdata_s = empty_s ? 32'd0 : 32'(head_s);
        OFF_CTRL[4:2]:     rdata_s = {30'd0, ctrl_q};
        default:           rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_q <= 32'd0;
      ctrl_q     <= 2'd0;
      ovf_q      <= 1'b0;
    end else begin
      port_out_q <= port_out_d;
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
    end
  end

  port_capture_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .clear_i (clear_s),
    .data_i  (push_data_s),
    .empty_o (empty_s),
    .full_o  (full_s),
    .count_o (count_s),
    .head_o  (head_s)
  );

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed plus randomized bench for mmio_port_responder against a queue-based reference model.
module tb_mmio_port_responder;
  localparam logic [31:0] BASE   = 32'h1001_0000;
  localparam logic [31:0] A_OUT  = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h08;
  localparam logic [31:0] A_FIFO = BASE + 32'h0C;
  localparam logic [31:0] A_CTRL = BASE + 32'h10;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        IrqPending;

  mmio_port_responder_if bus_if ();

  mmio_port_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .bus        (bus_if),
    .PortIn     (PortIn),
    .PortOut    (PortOut),
    .IrqPending (IrqPending)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_q[$];
  logic        m_ovf;
  logic [31:0] m_port;
  logic [1:0]  m_ctrl;
  logic [7:0]  hist[$];
  int          n;
  logic [31:0] obs_rd;
  logic        obs_hit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // PortIn as sampled on edge i since reset release; before that the synchronizer held zero
  function automatic logic [7:0] hv(input int i);
    if (i < 0 || i >= hist.size()) return 8'd0;
    return hist[i];
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    logic [31:0] off;
    int          sz;
    off = addr - BASE;
    sz  = m_q.size();
    if (off >= 32'd32) return 32'd0;
    case (off[4:2])
      3'd0:    return m_port;
      3'd1:    return {24'd0, hv(n - SYNC)};
      3'd2:    return {24'd0, 5'(sz), m_ovf, (sz == DEPTH), (sz == 0)};
      3'd3:    return (sz > 0) ? m_q[0] : 32'd0;
      3'd4:    return {30'd0, m_ctrl};
      default: return 32'd0;
    endcase
  endfunction

  task automatic cycle(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [7:0] pin);
    logic [31:0] off;
    logic        hit, pop, push, clr;
    logic [31:0] pv;
    bus_if.MemRead   = rd;
    bus_if.MemWrite  = wr;
    bus_if.Address   = addr;
    bus_if.WriteData = wd;
    PortIn           = pin;
    @(negedge clk);
    off     = addr - BASE;
    hit     = (off < 32'd32);
    obs_hit = bus_if.Hit;
    obs_rd  = bus_if.ReadData;
    check("Hit", 32'(obs_hit), 32'(hit));
    check("ReadData", obs_rd, model_rd(addr));
    hist.push_back(pin);
    pop  = rd && hit && (off[4:2] == 3'd3) && (m_q.size() > 0);
    push = m_ctrl[0] && (hv(n - SYNC) != hv(n - SYNC - 1));
`ifdef MMIO_PORT_TIMESTAMP_EN
    pv = {24'(n), hv(n - SYNC)};
`else
    pv = {24'd0, hv(n - SYNC)};
`endif
    clr = wr && hit && (off[4:2] == 3'd4) && wd[2];
    if (clr) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(pv);
        else                    m_ovf = 1'b1;
      end
    end
    if (wr && hit && off[4:2] == 3'd0) m_port = wd;
    if (wr && hit && off[4:2] == 3'd4) m_ctrl = wd[1:0];
    @(posedge clk);
    n++;
    #1;
    check("PortOut", PortOut, m_port);
    check("IrqPending", 32'(IrqPending), 32'((m_q.size() > 0) && m_ctrl[1]));
  endtask

  task automatic do_reset();
    bus_if.MemRead   = 1'b1;
    bus_if.MemWrite  = 1'b0;
    bus_if.Address   = A_STAT;
    bus_if.WriteData = 32'd0;
    rst_n = 1'b0;
    #1;
    check("reset PortOut", PortOut, 32'd0);
    check("reset IrqPending", 32'(IrqPending), 32'd0);
    check("reset STATUS", bus_if.ReadData, 32'h0000_0001);
    m_q.delete();
    m_ovf  = 1'b0;
    m_port = 32'd0;
    m_ctrl = 2'd0;
    hist.delete();
    n = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus_if.MemRead = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0]  pin;
    logic [31:0] a, wd;
    int          r, op;
    bus_if.MemRead = 1'b0; bus_if.MemWrite = 1'b0;
    bus_if.Address = 32'd0; bus_if.WriteData = 32'd0;
    PortIn = 8'd0;
    #2;
    do_reset();

    cycle(1'b0, 1'b1, A_OUT, 32'hDEAD_BEEF, 8'h00);
    check("sw PORT_OUT", PortOut, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b0, A_OUT, 32'd0, 8'h00);
    check("lw PORT_OUT", obs_rd, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b0, BASE + 32'h20, 32'd0, 8'h00);
    check("Hit above window", 32'(obs_hit), 32'd0);
    check("ReadData outside", obs_rd, 32'd0);
    cycle(1'b1, 1'b0, BASE - 32'd4, 32'd0, 8'h00);
    check("Hit below window", 32'(obs_hit), 32'd0);
    cycle(1'b0, 1'b1, BASE + 32'h1C, 32'h1234_5678, 8'h00);
    check("Hit last word", 32'(obs_hit), 32'd1);
    check("reserved reads 0", obs_rd, 32'd0);

    // single capture and its latency
    cycle(1'b0, 1'b1, A_CTRL, 32'h1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, A_STAT, 32'd0, 8'h5A);
      if (i == 2) check("STATUS before capture", obs_rd, 32'h01);
    end
    check("STATUS one entry", obs_rd, 32'h08);
    cycle(1'b1, 1'b0, A_FIFO, 32'd0, 8'h5A);
    check("pop 0x5A", obs_rd, 32'h5A);
    cycle(1'b1, 1'b0, A_STAT, 32'd0, 8'h5A);
    check("STATUS empty after pop", obs_rd, 32'h01);

    // five changes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b0, A_OUT, 32'd0, 8'(i * 17));
    repeat (2) cycle(1'b0, 1'b0, A_OUT, 32'd0, 8'h55);
    cycle(1'b1, 1'b0, A_STAT, 32'd0, 8'h55);
    check("STATUS full+overflow", obs_rd, 32'h26);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 1'b0, A_FIFO, 32'd0, 8'h55);
      check("pop order", obs_rd, 32'(i * 17));
    end
    cycle(1'b1, 1'b0, A_STAT, 32'd0, 8'h55);
    check("STATUS drained", obs_rd, 32'h05);

    // full FIFO with simultaneous push and pop
    cycle(1'b0, 1'b1, A_CTRL, 32'h5, 8'h55);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, A_OUT, 32'd0, 8'(8'h60 + i));
    repeat (2) cycle(1'b0, 1'b0, A_OUT, 32'd0, 8'h64);
    cycle(1'b1, 1'b0, A_STAT, 32'd0, 8'h65);
    check("STATUS full", obs_rd, 32'h22);
    cycle(1'b0, 1'b0, A_OUT, 32'd0, 8'h65);
    cycle(1'b1, 1'b0, A_FIFO, 32'd0, 8'h65);
    check("pop while push", obs_rd, 32'h61);
    cycle(1'b1, 1'b0, A_STAT, 32'd0, 8'h65);
    check("STATUS full no overflow", obs_rd, 32'h22);

    // overflow, partial drain, clear
    cycle(1'b0, 1'b0, A_OUT, 32'd0, 8'h66);
    repeat (2) cycle(1'b0, 1'b0, A_OUT, 32'd0, 8'h66);
    cycle(1'b1, 1'b0, A_STAT, 32'd0, 8'h66);
    check("STATUS overflow again", obs_rd, 32'h26);
    cycle(1'b1, 1'b0, A_FIFO, 32'd0, 8'h66);
    check("head advanced", obs_rd, 32'h62);
    cycle(1'b1, 1'b0, A_FIFO, 32'd0, 8'h66);
    check("pop 0x63", obs_rd, 32'h63);
    cycle(1'b1, 1'b0, A_STAT, 32'd0, 8'h66);
    check("STATUS two+overflow", obs_rd, 32'h14);
    cycle(1'b0, 1'b1, A_CTRL, 32'h4, 8'h66);
    cycle(1'b1, 1'b0, A_STAT, 32'd0, 8'h66);
    check("STATUS after clear", obs_rd, 32'h01);
    cycle(1'b1, 1'b0, A_CTRL, 32'd0, 8'h66);
    check("CTRL after clear", obs_rd, 32'h0);

    // reset with a captured entry and another change in flight
    cycle(1'b0, 1'b1, A_CTRL, 32'h3, 8'h66);
    repeat (3) cycle(1'b0, 1'b0, A_OUT, 32'd0, 8'h77);
    check("IrqPending with entry", 32'(IrqPending), 32'd1);
    cycle(1'b0, 1'b0, A_OUT, 32'd0, 8'h78);
    do_reset();

    // randomized traffic
    cycle(1'b0, 1'b1, A_CTRL, 32'h3, 8'h78);
    pin = 8'h78;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) pin = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      a = BASE + 32'h20 + 32'($urandom_range(0, 63));
      else if (r == 1) a = BASE - 32'($urandom_range(1, 16));
      else             a = BASE + 32'($urandom_range(0, 31));
      wd = $urandom;
      if (a - BASE == 32'h10 + 32'(a[1:0]) && $urandom_range(0, 7) != 0) wd[2] = 1'b0;
      op = $urandom_range(0, 9);
      if (op < 5)      cycle(1'b1, 1'b0, a, wd, pin);
      else if (op < 7) cycle(1'b0, 1'b1, a, wd, pin);
      else             cycle(1'b0, 1'b0, a, wd, pin);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O peripheral that responds to the MIPS core's data-memory accesses (MemRead/MemWrite/Address/WriteData).
- Drives the 32-bit PortOut register.
- Synchronizes the 8-bit PortIn and captures every input change into a small FIFO that software drains with lw.
- Sits beside DataMemory. The top level muxes ReadData into the load path when Hit=1 and gates the DataMemory write with !Hit.

Parameters:
- BASE_ADDR, 32'h1001_0000, word-aligned base of the 32-byte register window.
- FIFO_DEPTH, 4, capture FIFO entries; power of two, 2..16.
- SYNC_STAGES, 2, PortIn synchronizer flops; minimum 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  store strobe from control unit.
- MemRead  in  1  load strobe from control unit.
- Address  in  32  byte address (ALU result).
- WriteData  in  32  store data (rt).
- ReadData  out  32  load data; combinational from Address.
- Hit  out  1  Address within [BASE_ADDR, BASE_ADDR+0x1F]; combinational.
- PortIn  in  8  asynchronous external input.
- PortOut  out  32  output port register.
- IrqPending  out  1  FIFO non-empty AND CTRL.irq_en.

Behaviour:
- Register map, offsets from BASE_ADDR; Address[1:0] ignored:
  - 0x00 PORT_OUT: read/write.
  - 0x04 PORT_IN: read-only, {24'b0, synchronized PortIn}.
  - 0x08 STATUS: read-only. [0] empty, [1] full, [2] overflow (sticky), [7:3] count.
  - 0x0C FIFO_DATA: read pops; read-only.
  - 0x10 CTRL: read/write. [0] capture_en, [1] irq_en. [2] clear: write-only, self-clearing, reads 0.
  - 0x14..0x1C: read 0, writes ignored.
- Writes take effect at the clock edge ending the cycle with MemWrite=1 and Hit=1.
- Reads are combinational the same cycle, giving zero-wait-state single-cycle loads. ReadData=0 when Hit=0.
- Reset (async, reset=0):
  - PortOut=0, CTRL=0, FIFO empty, overflow=0.
  - Synchronizer and previous-sample flops = 0.
  - ReadData follows Address. IrqPending=0.
- Capture:
  - prev <= sync_out every cycle.
  - Change = (sync_out != prev) AND capture_en.
  - Push value = {24'b0, sync_out}.
  - Latency from PortIn change to entry visible: SYNC_STAGES+1 cycles.
- Pop: at the clock edge when MemRead=1, Hit=1, offset=0x0C, not empty.
  - ReadData during that cycle = head entry.
  - Read while empty returns 0 with no state change.
- Simultaneous push and pop:
  - Both occur; count unchanged.
  - When full this is legal and sets no overflow.
- Push when full without pop: entry dropped, overflow<=1.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Clear (CTRL write with bit2=1):
  - Empties FIFO, overflow<=0.
  - Has priority over a same-cycle push or pop.
  - bits[1:0] written normally.
- MemRead and MemWrite both 1: write performed, read data still driven. Does not occur with a legal control unit.
- Reset mid-operation: all state cleared immediately; no partial entries survive.

Optional Feature:
- Macro: MMIO_PORT_TIMESTAMP_EN.
- Defined:
  - 24-bit free-running cycle counter, reset 0, wraps at 2^24.
  - Each pushed entry = {counter[23:0], sync_out}, counter value at the push edge.
  - PORT_IN unaffected.
- Undefined: counter absent; FIFO entries store 8 bits; FIFO_DATA[31:8]=0.

Decomposition:
- Package mmio_port_pkg:
  - Offset constants OFF_PORT_OUT/OFF_PORT_IN/OFF_STATUS/OFF_FIFO/OFF_CTRL.
  - STATUS and CTRL bit-position constants.
  - Entry-width constant (32 or 8 per macro).
- One sub-module: port_capture_fifo.
  - Parameterized width/depth; push, pop, clear, empty, full, count, head.
  - Synchronous write, combinational head.
- Decode, registers and synchronizer stay in the top.

Test Plan:
- Reset 0 -> 1, sw 0xDEADBEEF to BASE+0x00 -> PortOut=0xDEADBEEF next edge. lw BASE+0x00 returns 0xDEADBEEF. Hit=0 at 0x1001_0020.
- CTRL=1, PortIn 0x00->0x5A -> after 3 cycles STATUS=0x08 (count 1), lw BASE+0x0C=0x5A, then STATUS=0x01 (empty).
- 5 distinct PortIn changes with FIFO_DEPTH=4, no reads -> STATUS=0x26 (count 4, full, overflow). Pops return the first four values in order; 5th value absent.
- With FIFO full, pop and push in the same cycle -> count stays 4, overflow stays 0, head advances.
- sw 0x4 to CTRL with 2 entries and overflow set -> STATUS=0x01, CTRL reads 0x0. Assert reset mid-capture -> PortOut=0, FIFO empty immediately.
- MMIO_PORT_TIMESTAMP_EN defined, change at counter=100 -> FIFO_DATA[31:8]=100+push latency offset, [7:0]=new value. Undefined -> [31:8]=0.
